// File: rtl/cos_pkg.sv
// cos_pkg -- shared definitions for the cosine series engine.
//   state_e      : FSM state encoding (also exported on the debug port)
//   Q8_ONE       : 1.0 in Q8.8 (256)
//   X_CLAMP      : largest accepted angle, ~pi in Q8.8 (804)
//   coef()       : Q8 series coefficients c1..c7
package cos_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SQUARE = 3'd1,
        MUL_X2 = 3'd2,
        MUL_C  = 3'd3,
        ACCUM  = 3'd4,
        DONE   = 3'd5
    } state_e;

    localparam logic [15:0] Q8_ONE  = 16'd256;
    localparam logic [15:0] X_CLAMP = 16'd804;

    // c_i approximates 256 / ((2i-1)*(2i)), the ratio between successive
    // Taylor terms of cos once x^2 has been factored out.
    function automatic logic [15:0] coef(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd1:    c = 16'd128;
            3'd2:    c = 16'd21;
            3'd3:    c = 16'd8;
            3'd4:    c = 16'd4;
            3'd5:    c = 16'd2;
            3'd6:    c = 16'd1;
            3'd7:    c = 16'd1;
            default: c = 16'd0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cos_series_engine_q8_mul.sv
// q8_mul -- combinational unsigned Q8 multiply.
//   a, b : 16-bit unsigned operands
//   p    : (a*b) >> 8, saturated to 0xFFFF
// Macro COS_SERIES_ROUND_EN: when defined, rounds to nearest (adds 128
// before the shift); otherwise the shift truncates.
module q8_mul (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] p
);

    logic [31:0] prod;
    logic [31:0] prod_adj;
    logic [23:0] shifted;

    always_comb begin
        prod = a * b;
`ifdef COS_SERIES_ROUND_EN
        // Cannot overflow: 0xFFFF*0xFFFF + 128 < 2^32.
        prod_adj = prod + 32'd128;
`else
        prod_adj = prod;
`endif
        shifted = prod_adj[31:8];
        p = (|shifted[23:16]) ? 16'hFFFF : shifted[15:0];
    end

endmodule

// File: rtl/cos_series_engine.sv
// cos_series_engine -- multi-cycle cos(x) by nested Taylor series.
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   start     : request pulse, sampled only in IDLE
//   x         : angle, unsigned Q8.8 radians (clamped to 804)
//   busy      : high in every state except IDLE
//   done      : one-cycle pulse, result valid
//   result    : cos(x), signed Q8.8, clamped to [-256, +256]
//   state_dbg : current FSM state
// Handshake: start is taken on a rising edge only when the engine is IDLE
// (busy low and not in DONE); done marks the single cycle in which a new
// result first appears, and result then holds until the next done.
// Macro COS_SERIES_ROUND_EN selects round-to-nearest in every multiply.
module cos_series_engine
    import cos_pkg::*;
#(
    parameter int N_TERMS = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [15:0]  x,
    output logic         busy,
    output logic         done,
    output logic [15:0]  result,
    output state_e       state_dbg
);

    localparam logic [2:0] LAST_IDX = 3'(N_TERMS);

    state_e             state_q, state_d;
    logic [15:0]        x_q, x_d;
    logic [15:0]        x2_q, x2_d;
    logic [15:0]        term_q, term_d;
    logic signed [17:0] sum_q, sum_d;
    logic [2:0]         idx_q, idx_d;
    logic [15:0]        result_q, result_d;

    logic [15:0]        mul_a, mul_b, mul_p;

    // One multiplier serves SQUARE, MUL_X2 and MUL_C; operands are steered
    // by state.
    q8_mul u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

    always_comb begin
        mul_a = 16'd0;
        mul_b = 16'd0;
        case (state_q)
            SQUARE: begin mul_a = x_q;    mul_b = x_q;         end
            MUL_X2: begin mul_a = term_q; mul_b = x2_q;        end
            MUL_C:  begin mul_a = term_q; mul_b = coef(idx_q); end
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            x_q      <= '0;
            x2_q     <= '0;
            term_q   <= '0;
            sum_q    <= '0;
            idx_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            x2_q     <= x2_d;
            term_q   <= term_d;
            sum_q    <= sum_d;
            idx_q    <= idx_d;
            result_q <= result_d;
        end
    end

    // Next-state and datapath.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        x2_d     = x2_q;
        term_d   = term_q;
        sum_d    = sum_q;
        idx_d    = idx_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d     = (x > X_CLAMP) ? X_CLAMP : x;
                    sum_d   = 18'(Q8_ONE);
                    term_d  = Q8_ONE;
                    idx_d   = 3'd1;
                    state_d = SQUARE;
                end
            end
            SQUARE: begin
                x2_d    = mul_p;
                state_d = MUL_X2;
            end
            MUL_X2: begin
                term_d  = mul_p;
                state_d = MUL_C;
            end
            MUL_C: begin
                term_d  = mul_p;
                state_d = ACCUM;
            end
            ACCUM: begin
                // Odd-index terms carry the minus sign of the series.
                if (idx_q[0]) sum_d = sum_q - $signed({2'b00, term_q});
                else          sum_d = sum_q + $signed({2'b00, term_q});
                idx_d = idx_q + 3'd1;
                if (idx_q == LAST_IDX) begin
                    // Result is captured on entry to DONE so it is valid
                    // in the same cycle as the done pulse.
                    if (sum_d > 18'sd256)       result_d = 16'd256;
                    else if (sum_d < -18'sd256) result_d = 16'hFF00;
                    else                        result_d = sum_d[15:0];
                    state_d = DONE;
                end else begin
                    state_d = MUL_X2;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs.
    always_comb begin
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        result    = result_q;
        state_dbg = state_q;
    end

endmodule

// File: tb/tb_cos_series_engine.sv
module tb_cos_series_engine;
    import cos_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] x = '0;
    logic        busy, done;
    logic [15:0] result;
    state_e      state_dbg;

    logic        start_n1 = 1'b0;
    logic [15:0] x_n1 = '0;
    logic        busy_n1, done_n1;
    logic [15:0] result_n1;
    state_e      state_n1;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    cos_series_engine #(.N_TERMS(6)) dut (
        .clk(clk), .rst(rst), .start(start), .x(x),
        .busy(busy), .done(done), .result(result), .state_dbg(state_dbg)
    );

    cos_series_engine #(.N_TERMS(1)) dut_n1 (
        .clk(clk), .rst(rst), .start(start_n1), .x(x_n1),
        .busy(busy_n1), .done(done_n1), .result(result_n1), .state_dbg(state_n1)
    );

    // Reference model: the nested series worked in plain integers.
    function automatic longint q8(input longint a, input longint b);
        longint p;
        p = a * b;
`ifdef COS_SERIES_ROUND_EN
        p = p + 128;
`endif
        p = p >>> 8;
        if (p > 65535) p = 65535;
        return p;
    endfunction

    function automatic logic [15:0] model(input int xin, input int n);
        longint xc, x2, term, sum;
        longint c [1:7];
        c = '{128, 21, 8, 4, 2, 1, 1};
        xc = (xin > 804) ? 804 : xin;
        x2 = q8(xc, xc);
        term = 256;
        sum = 256;
        for (int i = 1; i <= n; i++) begin
            term = q8(term, x2);
            term = q8(term, c[i]);
            if (i % 2 == 1) sum = sum - term;
            else            sum = sum + term;
        end
        if (sum > 256)  sum = 256;
        if (sum < -256) sum = -256;
        return 16'(sum);
    endfunction

    // Scoreboard: every done on the main instance pops one expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done result=%0d", $signed(result));
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (result !== e) begin
                    errors++;
                    $display("FAIL sb_result got=%0d exp=%0d", $signed(result), $signed(e));
                end
            end
        end
    end

    task automatic run_op(input logic [15:0] xin);
        int lat;
        repeat (2) @(negedge clk);
        x = xin;
        start = 1'b1;
        exp_q.push_back(model(int'(xin), 6));
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (done) begin lat = k; break; end
        end
        checks++;
        if (lat != 19) begin
            errors++;
            $display("FAIL latency x=%0d got=%0d exp=19", xin, lat);
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        start = 1'b1;  // must be ignored while rst is high
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 16'd0 || state_dbg !== IDLE) begin
            errors++;
            $display("FAIL reset_state busy=%b done=%b result=%0d state=%0d exp=0,0,0,IDLE",
                     busy, done, result, state_dbg);
        end
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (state_dbg !== IDLE || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle state=%0d busy=%b exp IDLE,0", state_dbg, busy);
        end
    endtask

    task automatic test_spec_points;
        run_op(16'd0);
        checks++;
        if (result !== 16'd256) begin
            errors++;
            $display("FAIL x0_result got=%0d exp=256", $signed(result));
        end
        run_op(16'd256);
        checks++;
`ifdef COS_SERIES_ROUND_EN
        if (result !== 16'd139) begin
            errors++;
            $display("FAIL x256_result got=%0d exp=139", $signed(result));
        end
`else
        if (result !== 16'd138) begin
            errors++;
            $display("FAIL x256_result got=%0d exp=138", $signed(result));
        end
`endif
        // result must hold while idle
        repeat (5) @(negedge clk);
        checks++;
        if (result !== model(256, 6)) begin
            errors++;
            $display("FAIL result_hold got=%0d exp=%0d", $signed(result), $signed(model(256, 6)));
        end
        run_op(16'd402);
        checks++;
        if ($signed(result) > 2 || $signed(result) < -2) begin
            errors++;
            $display("FAIL half_pi got=%0d exp=|r|<=2", $signed(result));
        end
        run_op(16'd804);
        checks++;
        if ($signed(result) > -252 || $signed(result) < -260) begin
            errors++;
            $display("FAIL pi got=%0d exp=-256+/-4", $signed(result));
        end
        run_op(16'hFFFF);
        checks++;
        if (result !== model(804, 6)) begin
            errors++;
            $display("FAIL clamp got=%0d exp=%0d", $signed(result), $signed(model(804, 6)));
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 6; i++) run_op(16'($urandom_range(0, 1100)));
    endtask

    task automatic test_ignore_start;
        int dcount, dedge;
        logic [15:0] xa, xb;
        xa = 16'd300;
        xb = 16'd700;
        repeat (2) @(negedge clk);
        exp_q.push_back(model(int'(xa), 6));
        dcount = 0;
        dedge = -1;
        for (int e = 1; e <= 40; e++) begin
            start = (e == 5 || e == 10);
            x = (e <= 5) ? xa : xb;
            @(posedge clk);
            #1;
            if (done) begin dcount++; dedge = e; end
        end
        start = 1'b0;
        checks++;
        if (dcount != 1 || dedge != 24) begin
            errors++;
            $display("FAIL ignore_start dones=%0d at=%0d exp=1 at 24", dcount, dedge);
        end
    endtask

    task automatic test_back_to_back;
        int d1, d2, dcount;
        repeat (2) @(negedge clk);
        x = 16'd100;
        start = 1'b1;
        exp_q.push_back(model(100, 6));
        exp_q.push_back(model(600, 6));
        @(posedge clk);
        #1 x = 16'd600;
        d1 = -1; d2 = -1; dcount = 0;
        for (int e = 1; e <= 45; e++) begin
            @(posedge clk);
            #1;
            if (done) begin
                dcount++;
                if (d1 < 0) d1 = e; else d2 = e;
            end
            if (e == 21) start = 1'b0;
        end
        checks++;
        if (dcount != 2 || d1 != 19 || d2 != 40) begin
            errors++;
            $display("FAIL back_to_back dones=%0d at=%0d,%0d exp=2 at 19,40", dcount, d1, d2);
        end
    endtask

    task automatic test_abort;
        int dcount;
        repeat (2) @(negedge clk);
        x = 16'd256;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (state_dbg !== MUL_C) begin
            errors++;
            $display("FAIL abort_setup state=%0d exp=MUL_C", state_dbg);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 16'd0 || state_dbg !== IDLE) begin
            errors++;
            $display("FAIL abort_reset busy=%b done=%b result=%0d state=%0d exp=0,0,0,IDLE",
                     busy, done, result, state_dbg);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        dcount = 0;
        for (int e = 0; e < 30; e++) begin
            @(posedge clk);
            #1;
            if (done) dcount++;
        end
        checks++;
        if (dcount != 0) begin
            errors++;
            $display("FAIL abort_no_done dones=%0d exp=0", dcount);
        end
        run_op(16'd0);
        checks++;
        if (result !== 16'd256) begin
            errors++;
            $display("FAIL after_abort got=%0d exp=256", $signed(result));
        end
    endtask

    task automatic test_n1;
        int lat;
        repeat (2) @(negedge clk);
        x_n1 = 16'd256;
        start_n1 = 1'b1;
        @(posedge clk);
        #1 start_n1 = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (done_n1) begin lat = k; break; end
        end
        checks++;
        if (lat != 4) begin
            errors++;
            $display("FAIL n1_latency got=%0d exp=4", lat);
        end
        checks++;
        if (result_n1 !== 16'd128) begin
            errors++;
            $display("FAIL n1_result got=%0d exp=128", $signed(result_n1));
        end
    endtask

    initial begin
        test_reset();
        test_spec_points();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_abort();
        test_n1();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain left=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cos_series_engine.md
COS_SERIES_ENGINE -- requirements
Module: cos_series_engine

Interface
REQ-001 SHALL have parameter N_TERMS, default 6, meaning the number of series terms after the constant term (range 1..7).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request pulse, sampled only in IDLE.
REQ-005 SHALL have port x  input  16  angle, unsigned Q8.8 radians.
REQ-006 SHALL have port busy  output  1  high in every state except IDLE.
REQ-007 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-008 SHALL have port result  output  16  cos(x), signed two's-complement Q8.8.

Function
REQ-009 SHALL evaluate cos(x) = 1 - x^2*c1*(1 - x^2*c2*(1 - ...)) as iterated terms: term0 = 256, term_i = ((term_{i-1}*x2)>>8)*c_i>>8, sum = sum of (-1)^i*term_i.
REQ-010 SHALL use Q8 coefficients c1..c7 = 128, 21, 8, 4, 2, 1, 1.
REQ-011 SHALL use FSM states IDLE, SQUARE, MUL_X2, MUL_C, ACCUM, DONE.
REQ-012 SHALL on start=1 in IDLE latch x (clamped to 804 if larger), set sum=256, term=256, index=1, go SQUARE.
REQ-013 SHALL in SQUARE register x2 = (x*x)>>8, go MUL_X2.
REQ-014 SHALL per term step MUL_X2 -> MUL_C -> ACCUM, one cycle each; ACCUM adds term when index is even, subtracts when odd, increments index.
REQ-015 SHALL leave ACCUM for DONE when index == N_TERMS, else return to MUL_X2.
REQ-016 SHALL in DONE assert done for exactly one cycle, load result, return to IDLE.
REQ-017 SHALL assert done exactly 3*N_TERMS+1 rising edges after the edge that sampled start (19 for default).
REQ-018 SHALL hold result stable from DONE until the next DONE.
REQ-019 SHALL ignore start while busy; start in the DONE cycle is ignored.
REQ-020 SHALL compute products in 32 bits, shift right 8, saturate term to 0xFFFF.
REQ-021 SHALL keep sum in 18-bit signed and clamp result to [-256, +256].
REQ-022 SHALL accept back-to-back operation: start in the first IDLE cycle after DONE is honoured.

Reset
REQ-023 SHALL, on rst high, immediately force state IDLE, busy=0, done=0, result=0, internal registers 0, including mid-computation; no done is produced for an aborted operation.
REQ-024 SHALL ignore start while rst is high.

Configuration
REQ-025 SHALL, with macro COS_SERIES_ROUND_EN defined, round every >>8 to nearest (add 128 before shift); without it, truncate.

Structure
REQ-026 SHALL place the state enum, coefficient table, Q8 one-constant (256) and angle clamp (804) in shared package cos_pkg.
REQ-027 SHALL instantiate one sub-module q8_mul (16x16 unsigned multiply, >>8, optional rounding, saturate) shared by SQUARE, MUL_X2 and MUL_C.

Verification
REQ-028 SHALL test x=0 -> done after 19 edges, result=256.
REQ-029 SHALL test x=256 (1.0 rad) -> result=138 truncating, 139 with COS_SERIES_ROUND_EN.
REQ-030 SHALL test x=402 (pi/2) -> |result| <= 2; x=804 (pi) -> result within -256 +/- 4; x=0xFFFF -> same result as x=804.
REQ-031 SHALL test start pulsed at cycles 5 and 10 -> exactly one done, at cycle 24, for the x latched at cycle 5.
REQ-032 SHALL test rst asserted during MUL_C of term 3 -> busy, done, result 0 same cycle, no later done; subsequent start x=0 -> 256.
REQ-033 SHALL test N_TERMS=1, x=256 -> done after 4 edges, result=128.
